// File: rtl/bram_2048x8.sv
// bram_2048x8: true dual-port 2048x8 synchronous RAM.
// Per-bit write masks, read-first, registered outputs.
module bram_2048x8 (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE0,
  input  logic [10:0] A0,
  input  logic [7:0]  D0,
  input  logic        WE0,
  input  logic [7:0]  WEM0,
  output logic [7:0]  Q0,
  input  logic        CE1,
  input  logic [10:0] A1,
  input  logic [7:0]  D1,
  input  logic        WE1,
  input  logic [7:0]  WEM1,
  output logic [7:0]  Q1
);

  logic [7:0] mem [0:2047];

  logic wr0;
  logic wr1;

  // Write strobes; reset suppresses every write on its edge.
  always_comb begin
    wr0 = 1'b0;
    wr1 = 1'b0;
    wr0 = CE0 & WE0 & ~RST;
    wr1 = CE1 & WE1 & ~RST;
  end

  // Bit-masked writes; port 1 is issued last so it wins shared bits.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 8; i++) begin
      if (wr0 && WEM0[i])
        mem[A0][i] <= D0[i];
      if (wr1 && WEM1[i])
        mem[A1][i] <= D1[i];
    end
  end

  // Port 0 read register: old word on writes, holds when idle.
  always_ff @(posedge CLK) begin
    if (RST)
      Q0 <= 8'h00;
    else if (CE0)
      Q0 <= mem[A0];
  end

  // Port 1 read register: old word on writes, holds when idle.
  always_ff @(posedge CLK) begin
    if (RST)
      Q1 <= 8'h00;
    else if (CE1)
      Q1 <= mem[A1];
  end

endmodule

// File: tb/tb_bram_2048x8.sv
// tb_bram_2048x8: scoreboard bench for bram_2048x8.
// Directed vectors plus a random soak against a model.
module tb_bram_2048x8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CE0 = 1'b0;
  logic [10:0] A0 = '0;
  logic [7:0]  D0 = '0;
  logic        WE0 = 1'b0;
  logic [7:0]  WEM0 = '0;
  logic [7:0]  Q0;
  logic        CE1 = 1'b0;
  logic [10:0] A1 = '0;
  logic [7:0]  D1 = '0;
  logic        WE1 = 1'b0;
  logic [7:0]  WEM1 = '0;
  logic [7:0]  Q1;

  bram_2048x8 dut (
    .CLK(CLK), .RST(RST),
    .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0),
    .WEM0(WEM0), .Q0(Q0),
    .CE1(CE1), .A1(A1), .D1(D1), .WE1(WE1),
    .WEM1(WEM1), .Q1(Q1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         chk;
    logic [7:0] exp;
    string      nm;
  } sb_t;

  sb_t sb0 [$];
  sb_t sb1 [$];

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] mm [0:2047];
  logic [7:0] q0m = 8'h00;
  logic [7:0] q1m = 8'h00;

  // Monitor: pops one expectation per port after each edge.
  always @(posedge CLK) begin
    sb_t e;
    #1;
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      if (e.chk) begin
        n_chk++;
        if (Q0 !== e.exp) begin
          n_fail++;
          $display("FAIL %s Q0: got %h expected %h",
                   e.nm, Q0, e.exp);
        end
      end
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      if (e.chk) begin
        n_chk++;
        if (Q1 !== e.exp) begin
          n_fail++;
          $display("FAIL %s Q1: got %h expected %h",
                   e.nm, Q1, e.exp);
        end
      end
    end
  end

  // k: 0 = no check, 1 = hand value e, 2 = model value
  task automatic cyc(
    input bit r,
    input bit c0, input bit w0, input logic [10:0] a0,
    input logic [7:0] d0, input logic [7:0] m0,
    input bit c1, input bit w1, input logic [10:0] a1,
    input logic [7:0] d1, input logic [7:0] m1,
    input int k0, input logic [7:0] e0,
    input int k1, input logic [7:0] e1,
    input string nm);
    logic [7:0] o0;
    logic [7:0] o1;
    sb_t s;
    @(negedge CLK);
    RST = r;
    CE0 = c0; WE0 = w0; A0 = a0; D0 = d0; WEM0 = m0;
    CE1 = c1; WE1 = w1; A1 = a1; D1 = d1; WEM1 = m1;
    o0 = mm[a0];
    o1 = mm[a1];
    if (r) begin
      q0m = 8'h00;
      q1m = 8'h00;
    end else begin
      if (c0) q0m = o0;
      if (c1) q1m = o1;
      if (c0 && w0) mm[a0] = (mm[a0] & ~m0) | (d0 & m0);
      if (c1 && w1) mm[a1] = (mm[a1] & ~m1) | (d1 & m1);
    end
    s.nm = nm;
    s.chk = (k0 != 0);
    s.exp = (k0 == 1) ? e0 : q0m;
    sb0.push_back(s);
    s.chk = (k1 != 0);
    s.exp = (k1 == 1) ? e1 : q1m;
    sb1.push_back(s);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mm[i] = 8'h00;

    cyc(1, 0,0,0,0,0, 0,0,0,0,0, 1,8'h00, 1,8'h00, "reset0");
    for (int i = 0; i < 1024; i++)
      cyc(0, 1,1,11'(2*i),0,8'hFF, 1,1,11'(2*i+1),0,8'hFF,
          0,0, 0,0, "fill");

    cyc(0, 1,1,5,8'hA5,8'hFF, 1,1,0,8'h5A,8'hFF,
        1,8'h00, 1,8'h00, "wr5_wr0");
    cyc(0, 1,0,5,0,0, 1,0,0,0,0, 1,8'hA5, 1,8'h5A, "rd5_rd0");
    cyc(1, 1,1,5,8'hFF,8'hFF, 1,0,5,0,0,
        1,8'h00, 1,8'h00, "reset_mid");
    cyc(0, 1,0,0,0,0, 1,0,5,0,0, 1,8'h5A, 1,8'hA5, "retain");

    cyc(0, 1,1,11'h7FF,8'h3C,8'hFF, 0,0,0,0,0,
        1,8'h00, 1,8'hA5, "wr7ff");
    cyc(0, 1,0,0,0,0, 1,0,11'h7FF,0,0,
        1,8'h5A, 1,8'h3C, "rd7ff_rd0");

    cyc(0, 1,1,10,8'hFF,8'hFF, 0,0,0,0,0,
        1,8'h00, 1,8'h3C, "wr10");
    cyc(0, 0,0,0,0,0, 1,1,10,8'h00,8'h0F,
        1,8'h00, 1,8'hFF, "mask0f");
    cyc(0, 0,0,0,0,0, 1,0,10,0,0, 1,8'h00, 1,8'hF0, "rd10");
    cyc(0, 0,0,0,0,0, 1,1,10,8'hAB,8'h00,
        1,8'h00, 1,8'hF0, "mask00");
    cyc(0, 0,0,0,0,0, 1,0,10,0,0, 1,8'h00, 1,8'hF0, "rd10b");

    cyc(0, 1,1,3,8'h11,8'hFF, 0,0,0,0,0,
        1,8'h00, 1,8'hF0, "wr3a");
    cyc(0, 1,1,3,8'h22,8'hFF, 0,0,0,0,0,
        1,8'h11, 1,8'hF0, "rdfirst");
    cyc(0, 1,0,3,0,0, 0,0,0,0,0, 1,8'h22, 1,8'hF0, "rd3");
    for (int i = 0; i < 3; i++)
      cyc(0, 0,1,3,8'h99,8'hFF, 0,0,0,0,0,
          1,8'h22, 1,8'hF0, "hold");
    cyc(0, 1,0,3,0,0, 0,0,0,0,0, 1,8'h22, 1,8'hF0, "rd3b");

    cyc(0, 1,1,7,8'hAA,8'hFF, 1,0,7,0,0,
        1,8'h00, 1,8'h00, "col_wr");
    cyc(0, 1,0,7,0,0, 1,0,7,0,0, 1,8'hAA, 1,8'hAA, "col_rr");
    cyc(0, 1,1,7,8'h0F,8'hF0, 1,1,7,8'hF0,8'h3C,
        1,8'hAA, 1,8'hAA, "col_ww");
    cyc(0, 1,0,7,0,0, 1,0,7,0,0, 1,8'h32, 1,8'h32, "col_rd");

    for (int n = 0; n < 10000; n++) begin
      bit r, c0, w0, c1, w1;
      logic [10:0] a0, a1;
      r  = ($urandom_range(0, 199) == 0);
      c0 = ($urandom_range(0, 3) != 0);
      c1 = ($urandom_range(0, 3) != 0);
      w0 = $urandom_range(0, 1);
      w1 = $urandom_range(0, 1);
      a0 = $urandom_range(0, 1) ? 11'($urandom_range(0, 7))
                                : 11'($urandom);
      a1 = $urandom_range(0, 1) ? 11'($urandom_range(0, 7))
                                : 11'($urandom);
      if (c0 && w0 && c1 && w1 && a0 == a1) a1 = a1 ^ 11'h1;
      cyc(r, c0,w0,a0,8'($urandom),8'($urandom),
          c1,w1,a1,8'($urandom),8'($urandom),
          2,0, 2,0, "soak");
    end

    @(negedge CLK);
    CE0 = 0; WE0 = 0; CE1 = 0; WE1 = 0;
    for (int i = 0; i < 5; i++) begin
      if (sb0.size() == 0 && sb1.size() == 0) break;
      @(negedge CLK);
    end
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending expected 0",
               sb0.size(), sb1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_2048x8.md
# bram_2048x8

Single-clock, true dual-port 2048-word × 8-bit synchronous block RAM with per-bit write masks. It is the leaf storage primitive that the generated SRAM wrappers instantiate as banks. Each port can read or write independently every cycle. Read data is registered, with one cycle of latency.

## Interface
Parameters: none. Geometry is fixed at 2048 × 8 (11-bit address, 8-bit data).

Ports:
- CLK  in  1  sole clock; all state updates on its rising edge. Both ports use this clock.
- RST  in  1  reset, synchronous and active-high.
- CE0  in  1  port 0 enable.
- A0  in  11  port 0 word address.
- D0  in  8  port 0 write data.
- WE0  in  1  port 0 write enable.
- WEM0  in  8  port 0 write mask; bit i = 1 allows D0[i] to be written.
- Q0  out  8  port 0 registered read data.
- CE1, A1, D1, WE1, WEM1, Q1: same as port 0, for port 1.

## Operation
- Storage: array mem[0..2047] of 8 bits.
  - Contents are undefined at power-up; simulation models initialise to 0.
  - RST never alters the contents.
- Port p access (p = 0, 1), evaluated at each rising CLK edge with RST = 0:
  - CEp = 0: no access, and Qp holds its previous value.
  - CEp = 1, WEp = 0 (read): Qp <= mem[Ap].
  - CEp = 1, WEp = 1 (write): for each bit i with WEMp[i] = 1, mem[Ap][i] <= Dp[i]. Bits with WEMp[i] = 0 are unchanged.
  - Write cycles also update Qp with the read-first value: Qp <= mem[Ap] as it was before this edge's write.
- WEMp = 0 with WEp = 1 is legal: no storage change, and it behaves as a read.
- Dp and WEMp are ignored when WEp = 0 or CEp = 0.
- Cross-port collisions (both CE = 1, same address):
  - Read/read: both ports return the same stored word.
  - One port writes, the other reads: the reader gets the old (pre-write) data.
  - Both write: for a bit enabled in both masks, port 1's data wins. A bit enabled in only one mask takes that port's data.
  - Wrappers treat write collisions as a usage error. The RAM itself must still be deterministic as specified above.
- RST = 1 at a rising edge:
  - Q0 and Q1 <= 0.
  - All writes on that edge are suppressed.
  - RST takes priority over CE and WE.
- Unused ports (CE = 0 permanently, inputs tied to 0) must synthesize cleanly.

## Timing
- Read latency is 1 cycle: address and CE are sampled at edge N, and Qp is valid after edge N and stays stable until the next enabled edge.
- A write at edge N is visible to a read issued at edge N+1 on either port.
- Reset value of every output: Q0 = 0x00, Q1 = 0x00, valid after the first edge with RST = 1.
- Reset mid-operation: a read issued in the RST cycle returns 0, not data. A write in the RST cycle is lost. Operations in the cycle after RST deasserts behave normally.
- No combinational path from any input to Q0/Q1.
- Full address range 0–2047; there is no wrap-around or out-of-range case.

## Test plan
- Reset:
  - Drive arbitrary Q values, then RST = 1 for 1 cycle → Q0 = Q1 = 0x00.
  - Write mem[5] = 0xA5, then assert RST, then read address 5 → 0xA5 (contents retained).
- Basic R/W:
  - Port 0 writes 0x3C to address 0x7FF with WEM0 = 0xFF.
  - Next cycle, port 1 reads 0x7FF → Q1 = 0x3C one cycle later.
  - Read address 0x000 → its own value, proving no aliasing.
- Bit mask:
  - mem[10] = 0xFF; port 1 writes D1 = 0x00 with WEM1 = 0x0F → read gives 0xF0.
  - Write with WEM = 0x00 → value unchanged, and Q shows 0xF0.
- Read-first and hold:
  - mem[3] = 0x11; port 0 writes 0x22 to address 3 → Q0 = 0x11 that cycle. Next read → 0x22.
  - Then drop CE0 for 3 cycles → Q0 stays 0x22.
- Collisions at address 7 (old value 0x00):
  - Port 0 writes 0xAA (WEM 0xFF) while port 1 reads → Q1 = 0x00, then mem = 0xAA.
  - Dual write, port 0 0x0F with WEM 0xF0 and port 1 0xF0 with WEM 0x3C → mem[7] = 0x30 | (0xAA & 0x03) = 0x32.
- Random soak: 10k cycles of random CE/WE/WEM/addresses on both ports, excluding write collisions → Q0/Q1 match a reference model every cycle.
